// File: rtl/accum_calc_stack_if.sv
// Control and result bundle for the accumulator calculator core.
// The master drives the strobe and operands; the slave returns registered state.
interface accum_calc_stack_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned IN_WIDTH = 3,
    parameter int unsigned DEPTH    = 4
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic                en;
    logic [2:0]          op;
    logic [IN_WIDTH-1:0] operand;
    logic                sat_mode;
    logic [WIDTH-1:0]    acc;
    logic                ovf;
    logic                err;
    logic [CntW-1:0]     hist_cnt;

    modport master (
        output en, op, operand, sat_mode,
        input  acc, ovf, err, hist_cnt
    );

    modport slave (
        input  en, op, operand, sat_mode,
        output acc, ovf, err, hist_cnt
    );
endinterface

// File: rtl/accum_calc_stack.sv
// Edge-triggered accumulator calculator with wrap/saturate arithmetic, status flags
// and a circular LIFO undo history of previous accumulator values.
module accum_calc_stack #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned IN_WIDTH = 3,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    accum_calc_stack_if.slave    bus
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpXor  = 3'b010,
        OpShl  = 3'b011,
        OpShr  = 3'b100,
        OpAnd  = 3'b101,
        OpLoad = 3'b110,
        OpUndo = 3'b111
    } op_e;

    logic             en_q, en_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [PtrW-1:0]  ptr_q, ptr_d;

    logic [WIDTH-1:0] hist_mem [DEPTH];

    logic             exec;
    logic             push;
    op_e              op_sel;
    logic [PtrW-1:0]  ptr_inc, ptr_dec;
    logic [WIDTH-1:0] x;
    logic             x_big;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] keep_mask;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign exec   = bus.en & ~en_q;
    assign op_sel = op_e'(bus.op);
    assign x      = WIDTH'(bus.operand);
    assign x_big  = (x >= WIDTH'(WIDTH));

    // ptr_q always names the next free slot; when full that slot holds the oldest entry.
    assign ptr_inc = (ptr_q == PtrW'(DEPTH - 1)) ? '0 : ptr_q + PtrW'(1);
    assign ptr_dec = (ptr_q == '0) ? PtrW'(DEPTH - 1) : ptr_q - PtrW'(1);

    always_comb begin
        alu_res   = acc_q;
        alu_ovf   = 1'b0;
        sum       = {1'b0, acc_q} + {1'b0, x};
        diff      = {1'b0, acc_q} - {1'b0, x};
        keep_mask = {WIDTH{1'b1}} >> x;
        unique case (op_sel)
            OpAdd: begin
                alu_ovf = sum[WIDTH];
                alu_res = (alu_ovf && bus.sat_mode) ? '1 : sum[WIDTH-1:0];
            end
            OpSub: begin
                alu_ovf = diff[WIDTH];
                alu_res = (alu_ovf && bus.sat_mode) ? '0 : diff[WIDTH-1:0];
            end
            OpXor: alu_res = acc_q ^ x;
            OpShl: begin
                if (x_big) begin
                    alu_res = '0;
                    alu_ovf = |acc_q;
                end else begin
                    alu_res = acc_q << x;
                    alu_ovf = |(acc_q & ~keep_mask);
                end
            end
            OpShr:  alu_res = x_big ? '0 : (acc_q >> x);
            OpAnd:  alu_res = acc_q & x;
            OpLoad: alu_res = x;
            OpUndo: alu_res = acc_q;
            default: alu_res = acc_q;
        endcase
    end

    always_comb begin
        en_d  = bus.en;
        acc_d = acc_q;
        ovf_d = ovf_q;
        err_d = err_q;
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        push  = 1'b0;
        if (exec) begin
            ovf_d = alu_ovf;
            err_d = 1'b0;
            if (op_sel == OpUndo) begin
                if (cnt_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    acc_d = hist_mem[ptr_dec];
                    ptr_d = ptr_dec;
                    cnt_d = cnt_q - CntW'(1);
                end
            end else begin
                push  = 1'b1;
                acc_d = alu_res;
                ptr_d = ptr_inc;
                if (cnt_q != CntW'(DEPTH)) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            en_q  <= 1'b0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
            ptr_q <= '0;
        end else begin
            en_q  <= en_d;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
        end
    end

    // Storage needs no reset: validity is tracked entirely by cnt_q.
    always_ff @(posedge clock) begin
        if (push) begin
            hist_mem[ptr_q] <= acc_q;
        end
    end

    assign bus.acc      = acc_q;
    assign bus.ovf      = ovf_q;
    assign bus.err      = err_q;
    assign bus.hist_cnt = cnt_q;
endmodule

// File: tb/tb_accum_calc_stack.sv
// Directed bench for accum_calc_stack: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_accum_calc_stack;
    localparam int unsigned W     = 8;
    localparam int unsigned IW    = 3;
    localparam int unsigned D     = 4;
    localparam int          MAXV  = (1 << W) - 1;

    logic clock = 1'b0;
    logic reset;

    accum_calc_stack_if #(.WIDTH(W), .IN_WIDTH(IW), .DEPTH(D)) bus ();

    accum_calc_stack #(.WIDTH(W), .IN_WIDTH(IW), .DEPTH(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Reference model: plain integers and a bounded queue of previous values.
    int m_acc;
    bit m_ovf, m_err, m_prev_en;
    int m_hist[$];

    always @(posedge clock) begin
        int x, old, t;
        if (reset) begin
            m_acc = 0; m_ovf = 0; m_err = 0; m_prev_en = 0;
            m_hist.delete();
        end else begin
            if (bus.en && !m_prev_en) begin
                x = int'(bus.operand);
                old = m_acc;
                m_ovf = 0;
                m_err = 0;
                case (bus.op)
                    3'd0: begin
                        t = old + x;
                        m_ovf = (t > MAXV);
                        m_acc = !m_ovf ? t : (bus.sat_mode ? MAXV : t - (MAXV + 1));
                    end
                    3'd1: begin
                        t = old - x;
                        m_ovf = (t < 0);
                        m_acc = !m_ovf ? t : (bus.sat_mode ? 0 : t + MAXV + 1);
                    end
                    3'd2: m_acc = old ^ x;
                    3'd3: begin
                        if (x >= W) begin
                            m_acc = 0;
                            m_ovf = (old != 0);
                        end else begin
                            t = old << x;
                            m_ovf = (t > MAXV);
                            m_acc = t & MAXV;
                        end
                    end
                    3'd4: m_acc = (x >= W) ? 0 : (old >> x);
                    3'd5: m_acc = old & x;
                    3'd6: m_acc = x;
                    default: begin
                        if (m_hist.size() == 0) m_err = 1;
                        else m_acc = m_hist.pop_back();
                    end
                endcase
                if (bus.op != 3'd7) begin
                    m_hist.push_back(old);
                    if (m_hist.size() > D) void'(m_hist.pop_front());
                end
            end
            m_prev_en = bus.en;
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            n_tests++;
            if (bus.acc !== W'(m_acc) || bus.ovf !== m_ovf || bus.err !== m_err ||
                bus.hist_cnt !== 3'(m_hist.size())) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got acc=%0d ovf=%b err=%b cnt=%0d want acc=%0d ovf=%b err=%b cnt=%0d",
                         $time, bus.acc, bus.ovf, bus.err, bus.hist_cnt,
                         m_acc, m_ovf, m_err, m_hist.size());
            end
        end
    end

    task automatic check_lit(input string name, input int e_acc, input bit e_ovf,
                             input bit e_err, input int e_cnt);
        n_tests++;
        if (bus.acc !== W'(e_acc) || bus.ovf !== e_ovf || bus.err !== e_err ||
            bus.hist_cnt !== 3'(e_cnt)) begin
            n_fail++;
            $display("FAIL %s dut got acc=%0d ovf=%b err=%b cnt=%0d want acc=%0d ovf=%b err=%b cnt=%0d",
                     name, bus.acc, bus.ovf, bus.err, bus.hist_cnt, e_acc, e_ovf, e_err, e_cnt);
        end
        n_tests++;
        if (m_acc != e_acc || m_ovf != e_ovf || m_err != e_err || m_hist.size() != e_cnt) begin
            n_fail++;
            $display("FAIL %s model got acc=%0d ovf=%b err=%b cnt=%0d want acc=%0d ovf=%b err=%b cnt=%0d",
                     name, m_acc, m_ovf, m_err, m_hist.size(), e_acc, e_ovf, e_err, e_cnt);
        end
    endtask

    // Called at a negedge; returns at a negedge after the op is visible and en is low.
    task automatic step_op(input logic [2:0] o, input int x, input bit sat);
        bus.op       = o;
        bus.operand  = IW'(x);
        bus.sat_mode = sat;
        bus.en       = 1'b1;
        @(negedge clock);
        bus.en = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        bus.en = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, SHL = 3'd3;
    localparam logic [2:0] SHR = 3'd4, AND = 3'd5, LOAD = 3'd6, UNDO = 3'd7;

    initial begin
        reset = 1'b1;
        bus.en = 1'b0;
        bus.op = '0;
        bus.operand = '0;
        bus.sat_mode = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk_on = 1'b1;
        check_lit("reset_state", 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clock);

        // Basic ops
        step_op(LOAD, 5, 0);
        step_op(ADD, 7, 0);  check_lit("load5_add7", 12, 0, 0, 2);
        step_op(XOR, 7, 0);  check_lit("xor7", 11, 0, 0, 3);
        step_op(AND, 3, 0);  check_lit("and3", 3, 0, 0, 4);

        // One execute per strobe while en is held
        do_reset();
        bus.op = ADD; bus.operand = 3'd1; bus.sat_mode = 1'b0; bus.en = 1'b1;
        repeat (5) @(negedge clock);
        check_lit("held_en_once", 1, 0, 0, 1);
        bus.en = 1'b0;
        @(negedge clock);
        bus.en = 1'b1;
        @(negedge clock);
        bus.en = 1'b0;
        @(negedge clock);
        check_lit("re_strobe", 2, 0, 0, 2);

        // Wrap vs saturate
        do_reset();
        step_op(SUB, 6, 0);  check_lit("sub_to_250", 250, 1, 0, 1);
        step_op(ADD, 7, 0);  check_lit("add_wrap", 1, 1, 0, 2);
        step_op(UNDO, 0, 0); check_lit("undo_to_250", 250, 0, 0, 1);
        step_op(ADD, 7, 1);  check_lit("add_sat", 255, 1, 0, 2);
        step_op(LOAD, 1, 0);
        step_op(SUB, 3, 0);  check_lit("sub_wrap", 254, 1, 0, 4);
        step_op(UNDO, 0, 0);
        step_op(SUB, 3, 1);  check_lit("sub_sat", 0, 1, 0, 4);

        // Shifts
        step_op(LOAD, 1, 0);
        step_op(SHL, 7, 0);  check_lit("shl7", 8'h80, 0, 0, 4);
        step_op(XOR, 1, 0);
        step_op(SHL, 1, 0);  check_lit("shl_out", 8'h02, 1, 0, 4);
        step_op(LOAD, 1, 0);
        step_op(SHL, 7, 0);
        step_op(SHR, 7, 0);  check_lit("shr7", 8'h01, 0, 0, 4);
        step_op(SHL, 0, 0);  check_lit("shl0", 8'h01, 0, 0, 4);

        // History overflow and underflow
        do_reset();
        step_op(LOAD, 1, 0);
        repeat (5) step_op(ADD, 1, 0);
        check_lit("hist_full", 6, 0, 0, 4);
        step_op(UNDO, 0, 0); check_lit("undo1", 5, 0, 0, 3);
        step_op(UNDO, 0, 0); check_lit("undo2", 4, 0, 0, 2);
        step_op(UNDO, 0, 0); check_lit("undo3", 3, 0, 0, 1);
        step_op(UNDO, 0, 0); check_lit("undo4", 2, 0, 0, 0);
        step_op(UNDO, 0, 0); check_lit("undo_empty", 2, 0, 1, 0);
        step_op(ADD, 1, 0);  check_lit("err_clear", 3, 0, 0, 1);

        // Reset mid-operation with en still high
        do_reset();
        step_op(LOAD, 5, 0);
        step_op(SHL, 3, 0);
        step_op(ADD, 0, 0);  check_lit("pre_rst", 40, 0, 0, 3);
        bus.op = ADD; bus.operand = 3'd2; bus.sat_mode = 1'b0;
        bus.en = 1'b1;
        reset  = 1'b1;
        @(negedge clock);
        check_lit("rst_mid", 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clock);
        check_lit("rst_release_exec", 2, 0, 0, 1);
        @(negedge clock);
        check_lit("rst_release_hold", 2, 0, 0, 1);
        bus.en = 1'b0;
        @(negedge clock);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
